mux_nway_rr: RTL
================

// Module: mux_nway_rr
// PURPOSE
//   Parametrised N-way, WIDTH-bit channel selector with a registered output and a
//   valid/ready handshake on every port. Generalises the fixed 8-way 16-bit mux.
//   Two selection modes:
//   - fixed-select: an external sel input picks the channel.
//   - round-robin arbitration: the block picks among the valid channels in turn.
//   Feeds shared 16-bit buses (memory / ALU operand ports) from several requesters.
// PARAMETERS
//   WIDTH  16  data width per channel
//   N      8   number of input channels (>=2; need not be a power of two)
//   SELW   3   select/channel-index width; must equal clog2(N); checked at elaboration
// PORTS
//   clk        in   1        single clock; all state on rising edge
//   rst_n      in   1        asynchronous, active-low reset
//   in_data    in   N*WIDTH  channel i at bits [i*WIDTH +: WIDTH]
//   in_valid   in   N        channel i presents data
//   in_ready   out  N        channel i word accepted this cycle (one-hot or zero)
//   mode       in   1        0 = fixed-select (sel), 1 = round-robin
//   sel        in   SELW     channel index used in fixed-select mode
//   out_data   out  WIDTH    registered selected word
//   out_chan   out  SELW     index of channel that supplied out_data
//   out_valid  out  1        out_data/out_chan hold a word
//   out_ready  in   1        downstream accepts word when out_valid && out_ready
// BEHAVIOUR
//   Reset (async assert, sync release): out_valid=0, out_data=0, out_chan=0, ptr=N-1.
//     Asserting reset mid-transfer drops the held word; in_ready is 0 during reset.
//   load_en = !out_valid || out_ready. The output register reloads only when load_en=1.
//   Grant (combinational, from current inputs):
//     - Fixed mode: grant=sel iff sel<N and in_valid[sel]. If sel>=N, no grant.
//     - RR mode: scan (ptr+1)..(ptr+N) mod N; the first valid channel wins.
//       With no valid channel, no grant.
//   Transfer in: when load_en and a grant exist, in_ready[grant]=1 (all others 0).
//     Next edge: out_data<=word, out_chan<=grant, out_valid<=1.
//     In RR mode only, ptr<=grant.
//   load_en=1 with no grant: out_valid<=0 next edge; out_data and out_chan keep their values.
//   Stall: while out_valid && !out_ready, out_data and out_chan are frozen, in_ready=0,
//     ptr is frozen, and sel/mode changes have no effect on the held word.
//   Timing: latency 1 cycle from in_valid&&in_ready to out_valid.
//     Throughput is 1 word/cycle when out_ready stays high.
//   Mode switch: takes effect on the next grant decision; ptr keeps its value.
//   Fixed mode never changes ptr.
//   Fairness: with all N channels valid in RR mode, each channel is granted once per N transfers.
//   Simultaneous drain+load (out_valid && out_ready && grant) = back-to-back words, no bubble.
// STRUCTURE
//   Shared header basics/mux_defs.vh:
//     - MUX_MODE_FIXED=1'b0, MUX_MODE_RR=1'b1
//     - constant clog2 function used for the SELW check
//   Sub-module rr_pick (combinational):
//     - inputs: req[N], ptr[SELW]
//     - outputs: gnt_idx[SELW], gnt_any
//   Top level holds the output register, ptr and the handshake logic.
//   No other hierarchy.
// TESTING
//   1) Reset with rst_n=0 and all in_valid=1 -> out_valid=0, out_data=0, in_ready=0.
//      Release reset -> first RR grant is channel 0.
//   2) Fixed mode, WIDTH=16/N=8, sel=5, in_valid=8'hFF, ch5=16'hBEEF, out_ready=1
//      -> in_ready=8'h20; next cycle out_data=16'hBEEF, out_chan=5.
//   3) RR mode, all valid, out_ready=1 for 10 cycles -> out_chan sequence 0..7,0,1.
//      in_ready is one-hot every cycle.
//   4) RR mode, in_valid=8'b0100_0100, ptr=2 -> grant 6, then 2, then 6.
//      Channels without valid are never granted.
//   5) Stall: out_ready=0 for 4 cycles with out_valid=1 -> out_data/out_chan are stable
//      and in_ready=0. Release -> next word on the cycle after, with no duplicate and no loss.
//   6) N=5, fixed mode, sel=6 -> no grant and out_valid falls to 0.
//      Assert rst_n=0 mid-stream -> out_valid drops immediately (async).

Source files
------------

// File: rtl/mux_nway_rr_pkg.sv
// Shared types and helpers for the N-way selector with fixed/round-robin modes.
package mux_nway_rr_pkg;

    typedef enum logic {
        MUX_MODE_FIXED = 1'b0,
        MUX_MODE_RR    = 1'b1
    } mux_mode_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/mux_nway_rr_if.sv
// Channel-side and output-side handshake bundle for mux_nway_rr.
interface mux_nway_rr_if #(
    parameter int WIDTH = 16,
    parameter int N     = 8,
    parameter int SELW  = 3
);
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic               mode;
    logic [SELW-1:0]    sel;
    logic [WIDTH-1:0]   out_data;
    logic [SELW-1:0]    out_chan;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_chan, out_valid
    );

    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_chan, out_valid
    );
endinterface

// File: rtl/mux_nway_rr_rr_pick.sv
// Combinational round-robin picker: first requester after ptr, wrapping mod N.
module rr_pick #(
    parameter int N    = 8,
    parameter int SELW = 3
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] gnt_idx,
    output logic            gnt_any
);
    // Scan from farthest to nearest so the closest requester after ptr wins last.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = N; k >= 1; k--) begin
            logic [SELW-1:0] idx;
            idx = SELW'((int'(ptr) + k) % N);
            if (req[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = idx;
            end
        end
    end
endmodule

// File: rtl/mux_nway_rr.sv
// N-way WIDTH-bit selector with registered output; fixed-select or round-robin grant.
module mux_nway_rr
    import mux_nway_rr_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int N     = 8,
    parameter int SELW  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    mux_nway_rr_if.slave      bus
);
    if (N < 2 || SELW != clog2(N)) begin : g_param_check
        $error("mux_nway_rr: SELW must equal clog2(N) and N must be >= 2");
    end

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_chan_q, out_chan_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  ptr_q, ptr_d;

    logic [SELW-1:0]      rr_idx;
    logic                 rr_any;
    logic [2**SELW-1:0]   valid_ext;
    logic                 fix_any;
    logic                 grant_any;
    logic [SELW-1:0]      grant_idx;
    logic                 load_en;
    logic [WIDTH-1:0]     grant_word;

    rr_pick #(.N(N), .SELW(SELW)) u_rr_pick (
        .req     (bus.in_valid),
        .ptr     (ptr_q),
        .gnt_idx (rr_idx),
        .gnt_any (rr_any)
    );

    // Zero-pad valids so an out-of-range sel reads a 0 instead of indexing past N.
    assign valid_ext = (2**SELW)'(bus.in_valid);
    assign fix_any   = (int'(bus.sel) < N) && valid_ext[bus.sel];

    always_comb begin
        grant_any = fix_any;
        grant_idx = bus.sel;
        if (mux_mode_e'(bus.mode) == MUX_MODE_RR) begin
            grant_any = rr_any;
            grant_idx = rr_idx;
        end
    end

    assign load_en    = !out_valid_q || bus.out_ready;
    assign grant_word = bus.in_data[int'(grant_idx)*WIDTH +: WIDTH];

    always_comb begin
        bus.in_ready = '0;
        if (rst_n && load_en && grant_any) begin
            bus.in_ready = {{(N-1){1'b0}}, 1'b1} << grant_idx;
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (load_en) begin
            out_valid_d = grant_any;
            if (grant_any) begin
                out_data_d = grant_word;
                out_chan_d = grant_idx;
                if (mux_mode_e'(bus.mode) == MUX_MODE_RR) begin
                    ptr_d = grant_idx;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= SELW'(N - 1);
        end else begin
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_chan  = out_chan_q;
    assign bus.out_valid = out_valid_q;
endmodule
